// File: rtl/test_014_if.sv
// rtl/test_014_if.sv - method-call handshake bundle for test_014 (req/busy/return).
`timescale 1ns/1ps
interface test_014_if;
  logic test_req;
  logic test_busy;
  logic test_return;

  modport master (output test_req, input test_busy, input test_return);
  modport slave  (input test_req, output test_busy, output test_return);
endinterface

// File: rtl/test_014.sv
// rtl/test_014.sv - self-checking fill/sum kernel returning (sum of 3i+1, i=0..15) == 376.
// Optional macro TEST014_FAULT_INJECT_EN corrupts a[5] so the result is always 0.
`timescale 1ns/1ps
module test_014 (
  input  logic       clk,
  input  logic       reset,
  test_014_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_SUM, S_CHECK} state_t;

  localparam logic [31:0] EXPECTED_SUM = 32'd376;

  state_t      state_q, state_d;
  logic [4:0]  i_q, i_d;
  logic [31:0] sum_q, sum_d;
  logic        busy_q, busy_d;
  logic        ret_q, ret_d;
  logic [31:0] a_q [16];
  logic [31:0] a_d [16];
  logic [31:0] init_val;

  always_comb begin
    init_val = ({27'd0, i_q} * 32'd3) + 32'd1;
`ifdef TEST014_FAULT_INJECT_EN
    if (i_q == 5'd5) begin
      init_val = 32'd17;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    sum_d   = sum_q;
    busy_d  = busy_q;
    ret_d   = ret_q;
    a_d     = a_q;
    case (state_q)
      S_IDLE: begin
        if (bus.test_req) begin
          busy_d  = 1'b1;
          i_d     = 5'd0;
          sum_d   = 32'd0;
          state_d = S_INIT;
        end
      end
      S_INIT: begin
        a_d[i_q[3:0]] = init_val;
        i_d           = i_q + 5'd1;
        if (i_q == 5'd15) begin
          i_d     = 5'd0;
          state_d = S_SUM;
        end
      end
      S_SUM: begin
        sum_d = sum_q + a_q[i_q[3:0]];
        i_d   = i_q + 5'd1;
        if (i_q == 5'd15) begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        ret_d   = (sum_q == EXPECTED_SUM);
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      i_q     <= 5'd0;
      sum_q   <= 32'd0;
      busy_q  <= 1'b0;
      ret_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      sum_q   <= sum_d;
      busy_q  <= busy_d;
      ret_q   <= ret_d;
    end
  end

  // Array needs no reset: INIT rewrites every entry before SUM reads it.
  always_ff @(posedge clk) begin
    a_q <= a_d;
  end

  assign bus.test_busy   = busy_q;
  assign bus.test_return = ret_q;

endmodule

// File: tb/tb_test_014.sv
// tb/tb_test_014.sv - directed bench for test_014; honours TEST014_FAULT_INJECT_EN.
`timescale 1ns/1ps
module tb_test_014;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic exp_ok;

  test_014_if bus ();

  test_014 u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic req;
    int   n;
    logic exp_busy;
    logic exp_ret;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Starts one call and returns how many sampled cycles busy stayed high.
  task automatic run_call(output int busy_cycles);
    bus.test_req = 1'b1;
    tick();
    bus.test_req = 1'b0;
    busy_cycles = 0;
    while (bus.test_busy && busy_cycles < 100) begin
      busy_cycles++;
      tick();
    end
  endtask

  initial begin
    int bc;
    int lows;
    int guard;
    checks   = 0;
    failures = 0;
`ifdef TEST014_FAULT_INJECT_EN
    exp_ok = 1'b0;
`else
    exp_ok = 1'b1;
`endif
    bus.test_req = 1'b0;
    reset = 1'b0;

    // Reset held 6 cycles, then 100 idle cycles.
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rst_busy", int'(bus.test_busy), 0);
      chk("rst_ret", int'(bus.test_return), 0);
    end
    reset = 1'b1;
    for (int k = 0; k < 100; k++) begin
      tick();
      chk("idle_busy", int'(bus.test_busy), 0);
      chk("idle_ret", int'(bus.test_return), 0);
    end

    // Single call, then a call with req toggled while busy.
    vecs.push_back('{1'b0, 5, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 32, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1, 1'b0, exp_ok});
    vecs.push_back('{1'b0, 5, 1'b0, exp_ok});
    vecs.push_back('{1'b1, 1, 1'b1, exp_ok});
    vecs.push_back('{1'b1, 10, 1'b1, exp_ok});
    vecs.push_back('{1'b0, 5, 1'b1, exp_ok});
    vecs.push_back('{1'b1, 17, 1'b1, exp_ok});
    vecs.push_back('{1'b0, 1, 1'b0, exp_ok});
    vecs.push_back('{1'b0, 4, 1'b0, exp_ok});
    foreach (vecs[v]) begin
      for (int k = 0; k < vecs[v].n; k++) begin
        bus.test_req = vecs[v].req;
        tick();
        chk($sformatf("vec%0d_busy", v), int'(bus.test_busy), int'(vecs[v].exp_busy));
        chk($sformatf("vec%0d_ret", v), int'(bus.test_return), int'(vecs[v].exp_ret));
      end
    end
    bus.test_req = 1'b0;

    // Held request: 1-cycle low pulses every 34 cycles.
    bus.test_req = 1'b1;
    tick();
    chk("held_start_busy", int'(bus.test_busy), 1);
    for (int p = 0; p < 3; p++) begin
      bc = 0;
      while (bus.test_busy && bc < 100) begin
        bc++;
        tick();
      end
      chk($sformatf("held_busy_len%0d", p), bc, 33);
      chk($sformatf("held_low_ret%0d", p), int'(bus.test_return), int'(exp_ok));
      lows = 0;
      while (!bus.test_busy && lows < 100) begin
        lows++;
        tick();
      end
      chk($sformatf("held_low_len%0d", p), lows, 1);
      chk($sformatf("held_period%0d", p), bc + lows, 34);
    end
    bus.test_req = 1'b0;
    guard = 0;
    while (bus.test_busy && guard < 100) begin
      guard++;
      tick();
    end
    chk("held_drain", int'(bus.test_busy), 0);

    // Reset at cycle 10 of an invocation, checked without a clock edge.
    bus.test_req = 1'b1;
    tick();
    bus.test_req = 1'b0;
    for (int k = 0; k < 9; k++) tick();
    chk("pre_rst_busy", int'(bus.test_busy), 1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_busy", int'(bus.test_busy), 0);
    chk("async_rst_ret", int'(bus.test_return), 0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("post_rst_idle", int'(bus.test_busy), 0);
    run_call(bc);
    chk("fresh_busy_len", bc, 33);
    chk("fresh_ret", int'(bus.test_return), int'(exp_ok));

    // Reset released while req already high: starts on first edge.
    reset = 1'b0;
    #1;
    bus.test_req = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("rel_req_busy", int'(bus.test_busy), 1);
    bus.test_req = 1'b0;
    bc = 1;
    while (bus.test_busy && bc < 100) begin
      tick();
      if (bus.test_busy) bc++;
    end
    chk("rel_req_len", bc, 33);
    chk("rel_req_ret", int'(bus.test_return), int'(exp_ok));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
